sdf_stage_ctrl: RTL and testbench
=================================

# sdf_stage_ctrl

Parameterized sequencer for one radix-2 single-path delay-feedback (SDF) butterfly stage of the 32-point FFT pipeline. One instance sits beside each stage's butterfly/delay-line datapath, with delay length L = 16, 8, 4, 2, 1 for stages 1 to 5. Each instance drives the delay-line shift enable, the butterfly/pass mux select, the twiddle index and the output valid/start-of-frame flags. It handles gapped input, back-to-back frames and the flush after the last frame.

## Interface
- N, 32, FFT size; power of two.
- L, 2, delay-line length of the stage; power of two, 1 ≤ L ≤ N/2.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  input sample present this cycle.
- ready_o  out  1  stage accepts a sample; accept = valid_i && ready_o.
- shift_en  out  1  advance the delay line and butterfly this cycle; combinational.
- sel  out  1  0 = load/pass phase, 1 = butterfly phase; combinational.
- tw_idx  out  log2(N)-1  twiddle index k of W_N^k; combinational.
- state  out  2  IDLE=0, RUN=1, DRAIN=2.
- valid_o  out  1  stage output register holds a real result; registered.
- sop_o  out  1  valid_o for output sample index 0 of a frame; registered.

## Operation
- Counters:
  - cnt (log2 N bits) holds the input sample index n within the frame and wraps N-1→0.
  - dcnt (log2 L bits, min 1) counts drain steps.
  - pcnt (log2 L + 1 bits) counts shift steps since leaving IDLE and saturates at L; primed = (pcnt == L).
  - ocnt (log2 N bits) counts output samples and wraps N-1→0.
- Shift position m is cnt in IDLE/RUN and dcnt in DRAIN.
- sel = m[log2 L] when state ≠ DRAIN; sel = 0 in DRAIN.
- tw_idx = (m mod L)·(N/(2L)) when sel=0; tw_idx = 0 when sel=1.
- shift_en = accept in IDLE/RUN; shift_en = 1 in DRAIN.
- ready_o = (state ≠ DRAIN).
- State transitions:
  - IDLE → RUN on accept; cnt becomes 1.
  - RUN: each accept increments cnt. valid_i low with cnt ≠ 0 is a gap: cnt holds and shift_en = 0.
  - RUN with cnt == 0 and valid_i high: back-to-back frame, stay in RUN.
  - RUN with cnt == 0 and valid_i low → DRAIN, dcnt = 0.
  - DRAIN: dcnt increments each cycle. After L cycles (dcnt == L-1) → IDLE, pcnt = 0.
- pcnt increments on every shift_en until it saturates at L.
- valid_o(t+1) = shift_en(t) && primed(t).
- sop_o(t+1) = valid_o(t+1) && ocnt == 0. ocnt increments on each valid_o.
- Invariant: total valid_o count equals total accepted samples.

## Timing
- Reset values: state=IDLE; cnt, dcnt, pcnt, ocnt = 0; valid_o=0, sop_o=0; sel=0, tw_idx=0, shift_en=0; ready_o=1. valid_i is ignored while rst is low.
- Latency: a sample accepted at shift step s exits the datapath at shift step s+L. valid_o rises one clk after that step.
- For a continuous frame starting at cycle 0, the first valid_o is at cycle L+1.
- The final frame needs exactly L drain cycles. ready_o is low for exactly those L cycles.
- An input gap inside a frame freezes every counter except ocnt. It also inserts an equal-length gap in valid_o once the stage is primed.
- Reset asserted mid-frame or mid-drain discards the partial frame. The next accepted sample is treated as n=0 with the stage unprimed.
- Only cnt==0 boundaries allow the RUN→DRAIN transition. A gap then resumption inside a frame never drains.

## Structure
- Shared package fft_pkg:
  - N=32 and LOG2N=5.
  - Twiddle index width LOG2N-1.
  - state encoding constants IDLE/RUN/DRAIN, reused by all stage controllers.
- No sub-module: four inline counters plus a 3-state FSM.
- Parameter check at elaboration: L a power of two and L ≤ N/2.

## Test plan
- L=2, one continuous 32-sample frame from cycle 0:
  - sel = 0,0,1,1 repeating; tw_idx = 0,8 in sel=0 cycles.
  - First valid_o at cycle 3, sop_o at cycle 3.
  - DRAIN cycles 32–33, ready_o=0 there, IDLE at 34, 32 valid_o pulses total.
- L=16, continuous frame:
  - sel=0 for n=0–15 with tw_idx=n·1 (0…15); sel=1 for n=16–31 with tw_idx=0.
  - First valid_o at cycle 17; 16 drain cycles.
- L=1, two back-to-back frames (64 valid cycles):
  - state stays RUN through cycle 63; sop_o on output indices 0 and 32.
  - One drain cycle at 64; 64 valid_o total.
- L=4, valid_i low for 3 cycles at n=10:
  - cnt holds 10 and shift_en=0 during the gap; valid_o shows a 3-cycle gap.
  - No DRAIN entered; output count is still 32.
- L=8, rst pulsed low at n=20:
  - All outputs return to reset values immediately.
  - A new frame after release gives first valid_o 9 cycles after its first accept.

Source files
------------

// File: rtl/fft_pkg.sv
// Constants and state encoding shared by every SDF stage controller of the
// 32-point FFT pipeline.
package fft_pkg;

  localparam int FFT_N     = 32;
  localparam int FFT_LOG2N = 5;
  localparam int TW_W      = FFT_LOG2N - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stage_state_e;

endpackage

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF butterfly stage: drives delay-line shift,
// butterfly/pass select, twiddle index and output valid/start-of-frame.
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int L = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   shift_en,
  output logic                   sel,
  output logic [$clog2(N)-2:0]   tw_idx,
  output logic [1:0]             state,
  output logic                   valid_o,
  output logic                   sop_o
);

  localparam int CW     = $clog2(N);
  localparam int LOG2L  = $clog2(L);
  localparam int DW     = (LOG2L > 0) ? LOG2L : 1;
  localparam int PW     = LOG2L + 1;
  localparam int STRIDE = N / (2 * L);

  generate
    if (L < 1 || (L & (L - 1)) != 0 || L > N / 2 || (N & (N - 1)) != 0) begin : g_bad_param
      $error("sdf_stage_ctrl: L must be a power of two with 1 <= L <= N/2");
    end
  endgenerate

  stage_state_e    state_q, state_d, cur_st;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [CW-1:0]   ocnt_q, ocnt_d;
  logic            valid_q, valid_d;
  logic            sop_q, sop_d;
  logic            accept, primed;
  logic [CW-1:0]   m, m_mod, tw_prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      ocnt_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      ocnt_q  <= ocnt_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
    end
  end

  // Handshake: a sample transfers on a rising clk edge when valid_i && ready_o.
  // A frame boundary (cnt==0) with valid_i low is already the first drain
  // cycle, so ready_o drops combinationally there; it is never low while
  // valid_i is high outside DRAIN.
  always_comb begin
    cur_st = state_q;
    if (state_q == RUN && cnt_q == '0 && !valid_i) cur_st = DRAIN;
    ready_o  = (cur_st != DRAIN);
    accept   = valid_i && ready_o && rst;
    shift_en = (cur_st == DRAIN) ? 1'b1 : accept;
    m        = (cur_st == DRAIN) ? CW'(dcnt_q) : cnt_q;
    sel      = (cur_st == DRAIN) ? 1'b0 : m[LOG2L];
    m_mod    = m & CW'(L - 1);
    tw_prod  = m_mod * CW'(STRIDE);
    tw_idx   = sel ? '0 : tw_prod[CW-2:0];
    state    = cur_st;
    primed   = (pcnt_q == PW'(L));
    valid_o  = valid_q;
    sop_o    = sop_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    pcnt_d  = pcnt_q;
    ocnt_d  = ocnt_q;
    valid_d = shift_en && primed;
    sop_d   = valid_d && (ocnt_q == '0);
    if (valid_d) ocnt_d = ocnt_q + 1'b1;
    if (shift_en && !primed) pcnt_d = pcnt_q + 1'b1;
    unique case (cur_st)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (accept) cnt_d = cnt_q + 1'b1;
      end
      DRAIN: begin
        if (dcnt_q == DW'(L - 1)) begin
          state_d = IDLE;
          dcnt_d  = '0;
          pcnt_d  = '0;
        end else begin
          state_d = DRAIN;
          dcnt_d  = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl: one instance per stage length L = 2, 16,
// 1, 4, 8, each exercised by a hand-derived cycle table.
module tb_sdf_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vi    [5];
  logic       ready [5];
  logic       shen  [5];
  logic       sel   [5];
  logic [3:0] tw    [5];
  logic [1:0] st    [5];
  logic       vo    [5];
  logic       sop   [5];

  int n_checks = 0;
  int n_errors = 0;
  int vo_count = 0;

  always #5 clk = ~clk;

  sdf_stage_ctrl #(.N(32), .L(2)) u_l2 (
    .clk(clk), .rst(rst), .valid_i(vi[0]), .ready_o(ready[0]), .shift_en(shen[0]),
    .sel(sel[0]), .tw_idx(tw[0]), .state(st[0]), .valid_o(vo[0]), .sop_o(sop[0]));
  sdf_stage_ctrl #(.N(32), .L(16)) u_l16 (
    .clk(clk), .rst(rst), .valid_i(vi[1]), .ready_o(ready[1]), .shift_en(shen[1]),
    .sel(sel[1]), .tw_idx(tw[1]), .state(st[1]), .valid_o(vo[1]), .sop_o(sop[1]));
  sdf_stage_ctrl #(.N(32), .L(1)) u_l1 (
    .clk(clk), .rst(rst), .valid_i(vi[2]), .ready_o(ready[2]), .shift_en(shen[2]),
    .sel(sel[2]), .tw_idx(tw[2]), .state(st[2]), .valid_o(vo[2]), .sop_o(sop[2]));
  sdf_stage_ctrl #(.N(32), .L(4)) u_l4 (
    .clk(clk), .rst(rst), .valid_i(vi[3]), .ready_o(ready[3]), .shift_en(shen[3]),
    .sel(sel[3]), .tw_idx(tw[3]), .state(st[3]), .valid_o(vo[3]), .sop_o(sop[3]));
  sdf_stage_ctrl #(.N(32), .L(8)) u_l8 (
    .clk(clk), .rst(rst), .valid_i(vi[4]), .ready_o(ready[4]), .shift_en(shen[4]),
    .sel(sel[4]), .tw_idx(tw[4]), .state(st[4]), .valid_o(vo[4]), .sop_o(sop[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input int idx, input string name, input int t,
                             input int e_st, input int e_rdy, input int e_sh,
                             input int e_sel, input int e_tw, input int e_vo,
                             input int e_sop);
    string p;
    p = $sformatf("%s@%0d", name, t);
    check({p, "_state"}, 32'(st[idx]),    32'(e_st));
    check({p, "_ready"}, 32'(ready[idx]), 32'(e_rdy));
    check({p, "_shift"}, 32'(shen[idx]),  32'(e_sh));
    check({p, "_sel"},   32'(sel[idx]),   32'(e_sel));
    check({p, "_tw"},    32'(tw[idx]),    32'(e_tw));
    check({p, "_vo"},    32'(vo[idx]),    32'(e_vo));
    check({p, "_sop"},   32'(sop[idx]),   32'(e_sop));
    if (vo[idx] === 1'b1) vo_count++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int e_st, e_sel, e_tw, n;
    logic v;

    // Reset with valid_i high on every instance: the input must be ignored.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) vi[i] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) check_cycle(i, "reset", 0, 0, 1, 0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) vi[i] = 1'b0;
    next_cycle();

    // L=2: one continuous frame, drain 32..33, IDLE at 34
    vo_count = 0;
    for (int t = 0; t < 36; t++) begin
      vi[0] = (t < 32);
      @(negedge clk);
      e_st  = (t == 0) ? 0 : (t < 32) ? 1 : (t < 34) ? 2 : 0;
      e_sel = (t < 32) ? ((t >> 1) & 1) : 0;
      e_tw  = (t < 32) ? (e_sel ? 0 : (t % 2) * 8) : (t < 34) ? (t - 32) * 8 : 0;
      check_cycle(0, "l2", t, e_st, (t == 32 || t == 33) ? 0 : 1, (t < 34) ? 1 : 0,
                  e_sel, e_tw, (t >= 3 && t <= 34) ? 1 : 0, (t == 3) ? 1 : 0);
      next_cycle();
    end
    check("l2_vo_total", 32'(vo_count), 32'd32);

    // L=16: continuous frame, 16 drain cycles
    vo_count = 0;
    for (int t = 0; t < 50; t++) begin
      vi[1] = (t < 32);
      @(negedge clk);
      e_st  = (t == 0) ? 0 : (t < 32) ? 1 : (t < 48) ? 2 : 0;
      e_sel = (t < 32 && t >= 16) ? 1 : 0;
      e_tw  = (t < 16) ? t : (t < 32) ? 0 : (t < 48) ? (t - 32) : 0;
      check_cycle(1, "l16", t, e_st, (t >= 32 && t < 48) ? 0 : 1, (t < 48) ? 1 : 0,
                  e_sel, e_tw, (t >= 17 && t <= 48) ? 1 : 0, (t == 17) ? 1 : 0);
      next_cycle();
    end
    check("l16_vo_total", 32'(vo_count), 32'd32);

    // L=1: two back-to-back frames, one drain cycle at 64
    vo_count = 0;
    for (int t = 0; t < 67; t++) begin
      vi[2] = (t < 64);
      @(negedge clk);
      e_st  = (t == 0) ? 0 : (t < 64) ? 1 : (t == 64) ? 2 : 0;
      e_sel = (t < 64) ? (t % 2) : 0;
      check_cycle(2, "l1", t, e_st, (t == 64) ? 0 : 1, (t < 65) ? 1 : 0,
                  e_sel, 0, (t >= 2 && t <= 65) ? 1 : 0, (t == 2 || t == 34) ? 1 : 0);
      next_cycle();
    end
    check("l1_vo_total", 32'(vo_count), 32'd64);

    // L=4: 3-cycle input gap at n=10, no drain inside the frame
    vo_count = 0;
    for (int t = 0; t < 41; t++) begin
      v = (t < 10) || (t >= 13 && t < 35);
      vi[3] = v;
      @(negedge clk);
      n     = (t < 10) ? t : (t < 13) ? 10 : t - 3;
      e_st  = (t == 0) ? 0 : (t < 35) ? 1 : (t < 39) ? 2 : 0;
      e_sel = (t < 35) ? ((n >> 2) & 1) : 0;
      e_tw  = (t < 35) ? (e_sel ? 0 : (n % 4) * 4) : (t < 39) ? ((t - 35) % 4) * 4 : 0;
      check_cycle(3, "l4", t, e_st, (t >= 35 && t < 39) ? 0 : 1,
                  ((t < 35 && v) || (t >= 35 && t < 39)) ? 1 : 0, e_sel, e_tw,
                  ((t >= 5 && t <= 10) || (t >= 14 && t <= 39)) ? 1 : 0, (t == 5) ? 1 : 0);
      next_cycle();
    end
    check("l4_vo_total", 32'(vo_count), 32'd32);

    // L=8: reset pulsed mid-frame at n=20, then a fresh frame
    for (int t = 0; t < 20; t++) begin
      vi[4] = 1'b1;
      @(negedge clk);
      e_sel = (t >> 3) & 1;
      check_cycle(4, "l8_pre", t, (t == 0) ? 0 : 1, 1, 1, e_sel,
                  e_sel ? 0 : (t % 8) * 2, (t >= 9) ? 1 : 0, (t == 9) ? 1 : 0);
      next_cycle();
    end
    rst = 1'b0;
    #1;
    check_cycle(4, "l8_rst", 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_cycle(4, "l8_rst", 1, 0, 1, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    vo_count = 0;
    for (int t = 0; t < 43; t++) begin
      vi[4] = (t < 32);
      @(negedge clk);
      e_st  = (t == 0) ? 0 : (t < 32) ? 1 : (t < 40) ? 2 : 0;
      e_sel = (t < 32) ? ((t >> 3) & 1) : 0;
      e_tw  = (t < 32) ? (e_sel ? 0 : (t % 8) * 2) : (t < 40) ? (t - 32) * 2 : 0;
      check_cycle(4, "l8", t, e_st, (t >= 32 && t < 40) ? 0 : 1, (t < 40) ? 1 : 0,
                  e_sel, e_tw, (t >= 9 && t <= 40) ? 1 : 0, (t == 9) ? 1 : 0);
      next_cycle();
    end
    check("l8_vo_total", 32'(vo_count), 32'd32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
